output_writer: RTL and testbench
================================

# output_writer

Upstream feeder for `output_ram`. It accepts computed result words from the compute core over a valid/ready handshake and buffers them in a 2-entry FIFO. It then drives the RAM write port (`we`, `i`, `pi`) with sequential addresses 0..r-1, one frame of r words per `start`. A `hold` input lets the write port be frozen without losing data.

## Interface
- r, 8, words per frame (1..2^aw)
- n, 32, data width; matches `output_ram` n
- aw, 5, address width of `i`; 2^aw >= r required
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (rst=0 resets immediately)
- start  in  1  begin a frame; sampled only in IDLE
- in_valid  in  1  upstream word available
- in_data  in  n  upstream word
- in_ready  out  1  block accepts in_data this cycle
- hold  in  1  1 = issue no RAM writes this cycle
- we  out  1  registered RAM write enable
- i  out  aw  registered RAM address
- pi  out  n  registered RAM write data
- busy  out  1  1 while in RUN
- done  out  1  one-cycle pulse, frame complete

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=0, busy=0. `start`=1 moves to RUN and clears acc_cnt, wr_cnt and the FIFO.
  - RUN: busy=1. Moves to DONE at the edge where the r-th word is popped.
  - DONE: done=1 for exactly one cycle, then IDLE unconditionally. `start` in DONE is ignored.
- `start` in RUN or DONE is ignored.
- in_ready is combinational from registered state only and never depends on in_valid: in_ready = (state==RUN) && (fifo_cnt<2) && (acc_cnt<r).
- Push when in_valid && in_ready. acc_cnt increments on each push.
- Pop when state==RUN, FIFO non-empty and hold==0. On the pop edge: we<=1, i<=wr_cnt, pi<=FIFO head, wr_cnt increments.
- No pop in a cycle: we<=0; i and pi hold their last values.
- FIFO ordering is strict first-in, first-out; words reach the RAM in acceptance order at addresses 0,1,...,r-1.
- Simultaneous push and pop with fifo_cnt==1: count stays 1, data order preserved.
- In-flight words cannot be dropped: push is impossible when fifo_cnt==2 because in_ready=0.
- Words offered after acc_cnt==r are not accepted; they stay pending upstream.
- Address wrap: the next frame restarts at i=0. wr_cnt never exceeds r-1 as a write address.
- hold may toggle any cycle, including the cycle of the final pop. The frame completes only when the r-th pop occurs.
- Reset (rst=0, any state, any time) has immediate effect:
  - state=IDLE, FIFO empty, counters=0;
  - we=0, i=0, pi=0, done=0, busy=0, in_ready=0.
  - Partially written frames are abandoned; no completion is signalled.

## Timing
- Word accepted at edge k with FIFO empty and hold=0: popped at edge k+1, so we/i/pi are valid during cycle k+1 and `output_ram` captures at edge k+2.
- Sustained throughput: 1 word/cycle with hold=0 and continuous in_valid.
- done: DONE is entered on the final pop edge, so done=1 in the same cycle as the final we=1 (i=r-1). busy falls in that cycle.
- in_ready returns to 1 at the earliest one cycle after `start`, i.e. in the first RUN cycle.
- hold=1 stops pops at the next edge. we is 0 in the cycle following the first held edge.
- Deasserting hold lets the next edge pop.

## Test plan
- Reset: drive rst=0 mid-run → we=0, i=0, pi=0, in_ready=0, busy=0, done=0 immediately, without waiting for a clock edge.
- Streaming frame (r=8): start, then continuous valid with data 10,2,4,6,8,12,14,16:
  - we=1 on 8 consecutive cycles with i=0..7 and pi matching in order;
  - done=1 coincides with i=7;
  - the system returns to IDLE one cycle later.
- Hold backpressure: hold=1, offer 3 words (10,2,4):
  - 2 accepted, then in_ready=0, we stays 0;
  - release hold → writes i=0:10, i=1:2, then the third word is accepted and written at i=2:4.
- Over-delivery: keep in_valid=1 after the 8th acceptance → in_ready=0, the 9th word is not consumed, exactly 8 writes occur.
- Reset mid-frame after 3 writes, then a new start with data 7,7,... → the first write lands at i=0 and no done pulse occurs for the abandoned frame.
- Ignored controls:
  - `start` pulsed during RUN does not restart counters;
  - in_valid=1 in IDLE is not accepted (in_ready=0, no we).

Source files
------------

// File: rtl/output_writer.sv
// output_writer: buffers result words in a 2-entry FIFO and streams each frame of r words
// into the output_ram write port at addresses 0..r-1, with hold freezing the port losslessly.
module output_writer #(
   parameter int r  = 8,
   parameter int n  = 32,
   parameter int aw = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          in_valid,
   input  logic [n-1:0]  in_data,
   output logic          in_ready,
   input  logic          hold,
   output logic          we,
   output logic [aw-1:0] i,
   output logic [n-1:0]  pi,
   output logic          busy,
   output logic          done
);
   localparam int cw = $clog2(r + 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state_q, state_d;
   logic [n-1:0] fifo_q [2];
   logic [n-1:0] fifo_d [2];
   logic [1:0] fifo_cnt_q, fifo_cnt_d;
   logic [cw-1:0] acc_cnt_q, acc_cnt_d, wr_cnt_q, wr_cnt_d;
   logic we_q, we_d;
   logic [aw-1:0] i_q, i_d;
   logic [n-1:0] pi_q, pi_d;
   logic push, pop, last_pop, clear, wslot;
   assign push     = in_valid && in_ready;
   assign pop      = state_q == RUN && fifo_cnt_q != 2'd0 && !hold;
   assign last_pop = pop && wr_cnt_q == cw'(r - 1);
   assign clear    = state_q == IDLE && start;
   // slot 0 is always the head; a push lands behind whatever survives this cycle's pop
   assign wslot    = fifo_cnt_q[0] && !pop;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else state_q <= state_d;
   end
   always_comb begin
      state_d = (state_q == IDLE && start)    ? RUN  :
                (state_q == RUN  && last_pop) ? DONE :
                (state_q == DONE)             ? IDLE : state_q;
   end
   always_comb begin
      in_ready = state_q == RUN && fifo_cnt_q < 2'd2 && acc_cnt_q < cw'(r);
      busy     = state_q == RUN;
      done     = state_q == DONE;
   end
   always_comb begin
      fifo_d = fifo_q;
      if (pop) fifo_d[0] = fifo_q[1];
      if (push) fifo_d[wslot] = in_data;
      fifo_cnt_d = clear ? 2'd0 : fifo_cnt_q + 2'(push) - 2'(pop);
      acc_cnt_d  = clear ? '0 : acc_cnt_q + cw'(push);
      wr_cnt_d   = clear ? '0 : wr_cnt_q + cw'(pop);
      we_d       = pop;
      i_d        = pop ? aw'(wr_cnt_q) : i_q;
      pi_d       = pop ? fifo_q[0] : pi_q;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fifo_q     <= '{default: '0};
         fifo_cnt_q <= '0;
         acc_cnt_q  <= '0;
         wr_cnt_q   <= '0;
         we_q       <= 1'b0;
         i_q        <= '0;
         pi_q       <= '0;
      end else begin
         fifo_q     <= fifo_d;
         fifo_cnt_q <= fifo_cnt_d;
         acc_cnt_q  <= acc_cnt_d;
         wr_cnt_q   <= wr_cnt_d;
         we_q       <= we_d;
         i_q        <= i_d;
         pi_q       <= pi_d;
      end
   end
   assign we = we_q;
   assign i  = i_q;
   assign pi = pi_q;
endmodule

// File: tb/tb_output_writer.sv
// tb_output_writer: randomized scoreboard bench; a count-based frame model predicts accepts and writes.
module tb_output_writer;
   localparam int R = 8, N = 32, AW = 5;
   logic clk = 0, rst = 1, start = 0, in_valid = 0, hold = 0;
   logic [N-1:0] in_data = '0;
   logic in_ready, we, busy, done;
   logic [AW-1:0] i;
   logic [N-1:0] pi;
   typedef struct packed {logic [AW-1:0] a; logic [N-1:0] d;} wr_t;
   wr_t sb[$];
   wr_t mon_e;
   int total = 0, bad = 0, nwr = 0;
   bit m_run = 0, m_done = 0, m_we = 0, m_idle, m_rdy, m_pop;
   int m_acc = 0, m_wr = 0;
   logic [N-1:0] stream [10] = '{10, 2, 4, 6, 8, 12, 14, 16, 18, 20};
   output_writer #(.r(R), .n(N), .aw(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .hold(hold), .we(we), .i(i), .pi(pi), .busy(busy), .done(done)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   // frame model: occupancy is accepted minus written; words are written in acceptance order
   initial forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
         m_run = 0; m_done = 0; m_we = 0; m_acc = 0; m_wr = 0;
         sb.delete();
      end else begin
         m_idle = !m_run && !m_done;
         m_rdy  = m_run && (m_acc - m_wr) < 2 && m_acc < R;
         m_pop  = m_run && m_acc > m_wr && !hold;
         if (m_rdy && in_valid) begin
            sb.push_back({AW'(m_acc), in_data});
            m_acc++;
         end
         m_we = m_pop;
         m_done = 0;
         if (m_pop) begin
            m_wr++;
            if (m_wr == R) begin m_run = 0; m_done = 1; end
         end
         if (m_idle && start) begin m_run = 1; m_acc = 0; m_wr = 0; end
      end
   end
   initial forever begin
      @(negedge clk);
      chk("in_ready", in_ready, m_run && (m_acc - m_wr) < 2 && m_acc < R);
      chk("we", we, m_we);
      chk("busy", busy, m_run);
      chk("done", done, m_done);
      if (we) begin
         if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_write: got i=%0d pi=%0h, expected no write", i, pi);
         end else begin
            mon_e = sb.pop_front();
            chk("addr", i, mon_e.a);
            chk("data", pi, mon_e.d);
            nwr++;
         end
      end
   end
   task automatic check_reset_outputs();
      chk("rst_we", we, 0);
      chk("rst_i", i, 0);
      chk("rst_pi", pi, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
   endtask
   task automatic run_frame(input int hold_first, input int hp, input int vp, input int sp,
                            input int abort_at, input int mode, output int cyc);
      logic [N-1:0] w[$];
      int idx = 0;
      bit took;
      for (int k = 0; k < R + 2; k++) w.push_back(mode == 0 ? stream[k] : mode == 1 ? 32'd7 : $urandom());
      nwr = 0;
      cyc = 0;
      start = 1;
      @(posedge clk); #1;
      start = 0;
      forever begin
         cyc++;
         if (!in_valid) in_valid = idx < w.size() && $urandom_range(99) < vp;
         in_data = idx < w.size() ? w[idx] : '0;
         hold = cyc <= hold_first || $urandom_range(99) < hp;
         start = $urandom_range(99) < sp;
         @(negedge clk); #1;
         took = in_valid && in_ready;
         if (done) begin
            chk("done_addr", i, R - 1);
            chk("done_we", we, 1);
            chk("frame_writes", nwr, R);
            chk("frame_leftover", sb.size(), 0);
            break;
         end
         if (abort_at != 0 && nwr >= abort_at) begin
            @(posedge clk); #1;
            in_valid = 0;
            rst = 0;
            #1 check_reset_outputs();
            @(posedge clk); #1;
            rst = 1;
            break;
         end
         if (cyc > 300) begin
            total++; bad++;
            $display("FAIL frame_timeout: got no done after %0d cycles, expected done", cyc);
            break;
         end
         @(posedge clk); #1;
         if (took) begin idx++; in_valid = 0; end
      end
      @(posedge clk); #1;
      in_valid = 0; hold = 0; start = 0;
   endtask
   initial begin
      int cyc;
      #2 rst = 0;
      #1 check_reset_outputs();
      @(posedge clk); #1;
      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      run_frame(0, 0, 100, 0, 0, 0, cyc);
      chk("stream_latency", cyc, 10);
      run_frame(4, 0, 100, 0, 0, 0, cyc);
      run_frame(0, 0, 100, 100, 0, 2, cyc);
      chk("start_in_run_latency", cyc, 10);
      in_valid = 1; in_data = 99;
      repeat (4) begin
         @(negedge clk); #1;
         chk("idle_in_ready", in_ready, 0);
      end
      @(posedge clk); #1;
      in_valid = 0;
      run_frame(0, 0, 100, 0, 3, 0, cyc);
      run_frame(0, 0, 100, 0, 0, 1, cyc);
      for (int f = 0; f < 12; f++) run_frame(0, 30, 70, 5, 0, 2, cyc);
      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
